// File: rtl/bf_io_responder_pkg.sv
// Shared encodings for the CPU I/O bus responder: FSM states, bus direction
// constants and the level-width helper.
package bf_io_responder_pkg;

    typedef enum logic [1:0] {
        IO_RSP_IDLE = 2'd0,
        IO_RSP_WAIT = 2'd1,
        IO_RSP_ACK  = 2'd2
    } io_rsp_state_t;

    localparam logic IO_DIR_READ  = 1'b0;
    localparam logic IO_DIR_WRITE = 1'b1;

    localparam logic [7:0] IO_EOF_DEFAULT = 8'h00;

    function automatic int level_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bf_byte_fifo.sv
// Byte FIFO with occupancy level and a combinational head.
// Push is ignored when full and pop is ignored when empty.
module bf_byte_fifo
    import bf_io_responder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LW    = level_bits(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic [7:0]    head
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bf_io_responder.sv
// Responder for the CPU I/O bus: completes CPU reads from the RX FIFO and
// CPU writes into the TX FIFO with a four-phase req/ack handshake.
module bf_io_responder
    import bf_io_responder_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 16,
    parameter int         LEVEL_WIDTH = 5,
    parameter logic [7:0] EOF_VALUE   = IO_EOF_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   io_req,
    input  logic                   io_dir,
    input  logic [7:0]             io_wdata,
    output logic                   io_ack,
    output logic [7:0]             io_rdata,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    input  logic                   in_eof,
    output logic [LEVEL_WIDTH-1:0] rx_level,
    output logic [LEVEL_WIDTH-1:0] tx_level
);

    io_rsp_state_t state;
    logic          dir_q;
    logic [7:0]    wdata_q;
    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    rx_head;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_pop;
    logic          tx_push;

    // These mirror the WAIT branches below so each request moves exactly one byte.
    assign rx_pop  = (state == IO_RSP_WAIT) && io_req && (dir_q == IO_DIR_READ) && !rx_empty;
    assign tx_push = (state == IO_RSP_WAIT) && io_req && (dir_q == IO_DIR_WRITE) && !tx_full;

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;

    bf_byte_fifo #(.DEPTH(FIFO_DEPTH), .LW(LEVEL_WIDTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level),
        .head      (rx_head)
    );

    bf_byte_fifo #(.DEPTH(FIFO_DEPTH), .LW(LEVEL_WIDTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (wdata_q),
        .pop       (tx_ready),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level),
        .head      (tx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IO_RSP_IDLE;
            io_ack   <= 1'b0;
            io_rdata <= 8'h00;
            dir_q    <= IO_DIR_READ;
            wdata_q  <= 8'h00;
        end else begin
            case (state)
                IO_RSP_IDLE: begin
                    if (io_req) begin
                        dir_q   <= io_dir;
                        wdata_q <= io_wdata;
                        state   <= IO_RSP_WAIT;
                    end
                end
                IO_RSP_WAIT: begin
                    // A request withdrawn before completion is abandoned silently.
                    if (!io_req) begin
                        state <= IO_RSP_IDLE;
                    end else if (dir_q == IO_DIR_READ) begin
                        if (!rx_empty) begin
                            io_rdata <= rx_head;
                            io_ack   <= 1'b1;
                            state    <= IO_RSP_ACK;
                        end else if (in_eof) begin
                            io_rdata <= EOF_VALUE;
                            io_ack   <= 1'b1;
                            state    <= IO_RSP_ACK;
                        end
                    end else if (!tx_full) begin
                        io_ack <= 1'b1;
                        state  <= IO_RSP_ACK;
                    end
                end
                IO_RSP_ACK: begin
                    if (!io_req) begin
                        io_ack <= 1'b0;
                        state  <= IO_RSP_IDLE;
                    end
                end
                default: begin
                    io_ack <= 1'b0;
                    state  <= IO_RSP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_io_responder.sv
// Self-checking bench for bf_io_responder: queue-based models of both FIFOs,
// all checks through one task, inputs driven and outputs sampled on negedge.
module tb_bf_io_responder;
    import bf_io_responder_pkg::*;

    localparam int         DEPTH = 16;
    localparam int         LW    = 5;
    localparam logic [7:0] EOFV  = 8'h00;

    logic          clk;
    logic          rst_n;
    logic          io_req;
    logic          io_dir;
    logic [7:0]    io_wdata;
    logic          io_ack;
    logic [7:0]    io_rdata;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          in_eof;
    logic [LW-1:0] rx_level;
    logic [LW-1:0] tx_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    bf_io_responder #(.FIFO_DEPTH(DEPTH), .LEVEL_WIDTH(LW), .EOF_VALUE(EOFV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_req   (io_req),
        .io_dir   (io_dir),
        .io_wdata (io_wdata),
        .io_ack   (io_ack),
        .io_rdata (io_rdata),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .in_eof   (in_eof),
        .rx_level (rx_level),
        .tx_level (tx_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic host_push(input logic [7:0] d);
        logic accept;
        accept   = (rx_exp_q.size() < DEPTH);
        rx_valid = 1'b1;
        rx_data  = d;
        check("rx_ready", 32'(rx_ready), 32'(accept));
        @(negedge clk);
        rx_valid = 1'b0;
        if (accept) rx_exp_q.push_back(d);
        check("rx_level_push", 32'(rx_level), 32'(rx_exp_q.size()));
    endtask

    task automatic host_pop();
        logic [7:0] exp_d;
        check("tx_valid", 32'(tx_valid), 32'd1);
        exp_d = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'h00;
        check("tx_data", 32'(tx_data), 32'(exp_d));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_level_pop", 32'(tx_level), 32'(tx_exp_q.size()));
    endtask

    task automatic cpu_start(input logic dir, input logic [7:0] d);
        io_req   = 1'b1;
        io_dir   = dir;
        io_wdata = d;
    endtask

    task automatic wait_ack(input string tag, input int budget, output int n);
        n = 0;
        while (!io_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(io_ack), 32'd1);
    endtask

    task automatic cpu_end();
        io_req = 1'b0;
        @(negedge clk);
        check("ack_fall", 32'(io_ack), 32'd0);
    endtask

    task automatic cpu_write(input logic [7:0] d, output int lat);
        cpu_start(IO_DIR_WRITE, d);
        wait_ack("wr_ack", 8, lat);
        if (io_ack) tx_exp_q.push_back(d);
        cpu_end();
    endtask

    task automatic cpu_read(input int hold, output int lat);
        logic [7:0] exp_d;
        exp_d = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : EOFV;
        cpu_start(IO_DIR_READ, 8'h00);
        wait_ack("rd_ack", 8, lat);
        check("rd_data", 32'(io_rdata), 32'(exp_d));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rd_hold_data", 32'(io_rdata), 32'(exp_d));
        end
        cpu_end();
        check("rx_level_rd", 32'(rx_level), 32'(rx_exp_q.size()));
    endtask

    initial begin
        int         lat;
        logic [7:0] exp_head;

        rst_n    = 1'b0;
        io_req   = 1'b0;
        io_dir   = 1'b0;
        io_wdata = 8'h00;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        in_eof   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_ack", 32'(io_ack), 32'd0);
        check("rst_rdata", 32'(io_rdata), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_level", 32'(rx_level), 32'd0);
        check("rst_tx_level", 32'(tx_level), 32'd0);

        // Single CPU write, then host drains it.
        cpu_write(8'h41, lat);
        check("wr_latency", 32'(lat), 32'd2);
        check("tx_level_1", 32'(tx_level), 32'd1);
        host_pop();
        check("tx_empty_after", 32'(tx_valid), 32'd0);

        // Two host bytes, two CPU reads; the first holds req for 5 cycles.
        host_push(8'h07);
        host_push(8'h09);
        check("rx_level_2", 32'(rx_level), 32'd2);
        cpu_read(5, lat);
        check("rd_latency", 32'(lat), 32'd2);
        cpu_read(0, lat);

        // Read stalls on empty RX until a byte arrives.
        cpu_start(IO_DIR_READ, 8'h00);
        repeat (10) @(negedge clk);
        check("rd_stall", 32'(io_ack), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        @(negedge clk);
        rx_valid = 1'b0;
        wait_ack("rd_late_ack", 4, lat);
        check("rd_late_data", 32'(io_rdata), 32'h33);
        cpu_end();
        check("rx_level_late", 32'(rx_level), 32'd0);

        // EOF read on empty RX.
        in_eof = 1'b1;
        cpu_read(0, lat);
        check("eof_latency", 32'(lat), 32'd2);
        in_eof = 1'b0;

        // Fill TX, stall the 17th write, release it with one host pop.
        for (int i = 0; i < DEPTH; i++) cpu_write(8'(8'h80 + i), lat);
        check("tx_full_level", 32'(tx_level), 32'(DEPTH));
        cpu_start(IO_DIR_WRITE, 8'hA5);
        repeat (5) @(negedge clk);
        check("tx_stall", 32'(io_ack), 32'd0);
        host_pop();
        wait_ack("tx_late_ack", 4, lat);
        tx_exp_q.push_back(8'hA5);
        check("tx_level_refill", 32'(tx_level), 32'(DEPTH));
        cpu_end();
        for (int i = 0; i < DEPTH; i++) host_pop();
        check("tx_drained", 32'(tx_valid), 32'd0);

        // RX at 15: simultaneous host push and CPU pop.
        for (int i = 0; i < DEPTH - 1; i++) host_push(8'($urandom_range(0, 255)));
        cpu_start(IO_DIR_READ, 8'h00);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h5C;
        exp_head = rx_exp_q.pop_front();
        rx_exp_q.push_back(8'h5C);
        @(negedge clk);
        rx_valid = 1'b0;
        check("same_cycle_ack", 32'(io_ack), 32'd1);
        check("same_cycle_data", 32'(io_rdata), 32'(exp_head));
        check("same_cycle_level", 32'(rx_level), 32'(DEPTH - 1));
        cpu_end();
        host_push(8'hE1);
        check("rx_full_ready", 32'(rx_ready), 32'd0);
        host_push(8'hEE);
        check("rx_full_level", 32'(rx_level), 32'(DEPTH));

        // Reset mid-transfer with bytes in RX.
        rst_n = 1'b0;
        #1;
        rx_exp_q.delete();
        tx_exp_q.delete();
        check("rst2_rx_level", 32'(rx_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) host_push(8'(8'h10 + i));
        cpu_start(IO_DIR_READ, 8'h00);
        wait_ack("pre_rst_ack", 8, lat);
        rst_n = 1'b0;
        #1;
        rx_exp_q.delete();
        check("rst_mid_ack", 32'(io_ack), 32'd0);
        check("rst_mid_rx_level", 32'(rx_level), 32'd0);
        check("rst_mid_tx_level", 32'(tx_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_stall", 32'(io_ack), 32'd0);
        io_req = 1'b0;
        repeat (2) @(negedge clk);

        // Randomised push/read pairs with random hold times.
        for (int i = 0; i < 8; i++) begin
            host_push(8'($urandom_range(0, 255)));
            cpu_read($urandom_range(0, 3), lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bf_io_responder.md
Name: bf_io_responder

Overview:
- Responder end of the CPU I/O bus (io_req/io_dir/io_wdata/io_ack/io_rdata). The CPU core is the only initiator on that bus.
- Completes CPU input (',') and output ('.') transfers against two byte FIFOs.
- RX FIFO: host to CPU. TX FIFO: CPU to host. Host side uses valid/ready byte streams.
- Sits between the CPU core and a UART/testbench byte source/sink.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; power of two, >= 2.
- LEVEL_WIDTH, 5, width of level outputs; must equal log2(FIFO_DEPTH)+1.
- EOF_VALUE, 8'h00, byte returned on a CPU read when RX is empty and in_eof=1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- io_req  in  1  CPU request; held high until io_ack is seen.
- io_dir  in  1  0=READ (CPU input), 1=WRITE (CPU output); same encoding as the shared direction constants.
- io_wdata  in  8  byte to output; valid while io_req=1 and io_dir=1.
- io_ack  out  1  transfer complete.
- io_rdata  out  8  input byte; valid while io_ack=1 on a read.
- rx_valid  in  1  host byte available.
- rx_data  in  8  host byte.
- rx_ready  out  1  RX FIFO can accept; equals !rx_full.
- tx_valid  out  1  TX byte available; equals !tx_empty.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  host accepts the TX byte.
- in_eof  in  1  host input exhausted.
- rx_level  out  LEVEL_WIDTH  RX occupancy.
- tx_level  out  LEVEL_WIDTH  TX occupancy.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, io_ack=0, io_rdata=0.
  - Both FIFOs empty: pointers and levels 0, rx_ready=1, tx_valid=0.
- Four-phase handshake, FSM states IDLE, WAIT, ACK:
  - IDLE: io_req=1 sampled -> go to WAIT. io_dir/io_wdata are captured at this edge.
  - WAIT, read: RX non-empty -> pop head into io_rdata, io_ack<=1, go to ACK.
  - WAIT, read: RX empty and in_eof=1 -> io_rdata<=EOF_VALUE, io_ack<=1, go to ACK; no pop.
  - WAIT, read: RX empty and in_eof=0 -> stay in WAIT indefinitely.
  - WAIT, write: TX not full -> push captured byte, io_ack<=1, go to ACK. Otherwise stay in WAIT.
  - ACK: hold io_ack=1 and io_rdata. When io_req=0 is sampled -> io_ack<=0, go to IDLE.
  - Exactly one push or pop per request, however long io_req stays high.
- Latency:
  - Minimum 2 edges from io_req sampled high to io_ack high.
  - io_ack falls 1 edge after io_req is sampled low.
- io_req dropping while in WAIT is a protocol violation: return to IDLE with no transfer and no ack.
- FIFO rules:
  - Push happens when valid & ready. Pop happens at the edge that raises io_ack (RX) or on tx_valid & tx_ready (TX).
  - Full is level==FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH; level never wraps.
  - Host push and CPU pop in the same cycle: both take effect, level unchanged.
  - RX full: rx_ready=0; a host byte presented while full is not consumed.
  - TX: CPU push and host pop in the same cycle on a full FIFO is not possible, because push requires !full at the start of the cycle. On a non-full FIFO both take effect.
  - tx_data is the current head, combinational from storage.
- Reset mid-transfer: io_ack drops immediately and FIFO contents are lost. If io_req is still high after release, it is a new request.
- rx_data/io_rdata content never alters control flow; arithmetic is pure 8-bit pass-through.

Decomposition:
- Shared macros/package:
  - FSM state encodings IO_RSP_IDLE/WAIT/ACK alongside the existing states macros.
  - Reuse the existing direction constants for io_dir.
- One sub-module: bf_byte_fifo (parameter DEPTH; push/pop/full/empty/level/head). Instantiate it twice.
- The FSM stays in bf_io_responder.

Test Plan:
- CPU write 8'h41 with tx_ready=1 -> io_ack high 2 edges after io_req; tx_valid=1, tx_data=8'h41; level returns to 0 after one host pop.
- Host pushes 8'h07 then 8'h09; two CPU reads -> io_rdata 8'h07 then 8'h09 while ack high; rx_level goes 2->1->0; no double pop with io_req held 5 cycles.
- CPU read on empty RX with in_eof=0 for 10 cycles -> io_ack stays 0. Then rx_valid with 8'h33 -> ack with io_rdata=8'h33. Repeat with in_eof=1 and RX empty -> immediate ack with io_rdata=EOF_VALUE, rx_level unchanged.
- With tx_ready=0, 16 CPU writes fill TX; 17th write stalls in WAIT. One host pop -> 17th acked; order preserved across pointer wrap; tx_level=16.
- RX at 15 entries: host push and CPU pop in the same cycle -> rx_level stays 15. Fill to 16 -> rx_ready=0; an extra host byte is not consumed.
- Assert rst_n=0 while io_ack=1 with 3 bytes in RX -> io_ack=0 immediately; levels 0. With io_req still high after release -> treated as a new read and stalls in WAIT.
